// File: rtl/addr8s_result_monitor.sv
// rtl/addr8s_result_monitor.sv - checks adder results against a golden sum, counts mismatches, forwards beats
module addr8s_result_monitor #(
    parameter int CNT_W       = 16,
    parameter bit HALT_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [8:0]       in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       out_sum,
    output logic             out_mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] samp_cnt,
    output logic [CNT_W-1:0] mism_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q;
    logic             out_valid_q, out_valid_d;
    logic [8:0]       out_sum_q, out_sum_d;
    logic             out_mis_q, out_mis_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] samp_q, samp_d;
    logic [CNT_W-1:0] mism_q, mism_d;

    logic [8:0]       golden_sum;
    logic             beat_mismatch;
    logic             accept;

    // Sign-extend both operands to 9 bits; the sum of two 8-bit signed values always fits
    assign golden_sum    = {in_a[7], in_a} + {in_b[7], in_b};
    assign beat_mismatch = (in_sum != golden_sum);

    // Ready depends only on registers and out_ready so the upstream never sees a loop through in_valid
    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-entry output stage: load on accept, drain when the consumer takes it, otherwise hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_mis_d   = out_mis_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_sum_d   = in_sum;
            out_mis_d   = beat_mismatch;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Statistics: clr wins over everything; beats seen during clr are forwarded but not counted
    always_comb begin
        samp_d = samp_q;
        mism_d = mism_q;
        err_d  = err_q;
        if (clr) begin
            samp_d = '0;
            mism_d = '0;
            err_d  = 1'b0;
        end else if (accept) begin
            if (samp_q != CNT_MAX) begin
                samp_d = samp_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (beat_mismatch) begin
                err_d = 1'b1;
                if (mism_q != CNT_MAX) begin
                    mism_d = mism_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Datapath and statistics registers; reset drops any pending output entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_mis_q   <= 1'b0;
            err_q       <= 1'b0;
            samp_q      <= '0;
            mism_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_mis_q   <= out_mis_d;
            err_q       <= err_d;
            samp_q      <= samp_d;
            mism_q      <= mism_d;
        end
    end

    // Control FSM: a counted mismatch halts intake (when enabled) until clr; clr alone never moves IDLE/RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (HALT_ON_ERR && accept && beat_mismatch && !clr) begin
                        state_q <= ST_HALT;
                    end else if (!en) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    if (clr) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_mismatch = out_mis_q;
    assign err_sticky   = err_q;
    assign samp_cnt     = samp_q;
    assign mism_cnt     = mism_q;
    assign state        = state_q;

endmodule

// File: tb/tb_addr8s_result_monitor.sv
// tb/tb_addr8s_result_monitor.sv - randomized and directed checks of addr8s_result_monitor
module tb_addr8s_result_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_a = '0, in_b = '0;
    logic [8:0] in_sum = '0;

    logic        d_rdy, d_ovld, d_omis, d_err;
    logic [8:0]  d_osum;
    logic [15:0] d_samp, d_mism;
    logic [1:0]  d_state;
    logic        s_rdy, s_ovld, s_omis, s_err;
    logic [8:0]  s_osum;
    logic [1:0]  s_samp, s_mism;
    logic [1:0]  s_state;
    logic        h_rdy, h_ovld, h_omis, h_err;
    logic [8:0]  h_osum;
    logic [15:0] h_samp, h_mism;
    logic [1:0]  h_state;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    addr8s_result_monitor #(.CNT_W(16), .HALT_ON_ERR(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .in_ready(d_rdy),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .out_valid(d_ovld), .out_ready(out_ready),
        .out_sum(d_osum), .out_mismatch(d_omis), .err_sticky(d_err), .samp_cnt(d_samp),
        .mism_cnt(d_mism), .state(d_state));

    addr8s_result_monitor #(.CNT_W(2), .HALT_ON_ERR(1'b0)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .in_ready(s_rdy),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .out_valid(s_ovld), .out_ready(out_ready),
        .out_sum(s_osum), .out_mismatch(s_omis), .err_sticky(s_err), .samp_cnt(s_samp),
        .mism_cnt(s_mism), .state(s_state));

    addr8s_result_monitor #(.CNT_W(16), .HALT_ON_ERR(1'b1)) u_halt (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .in_ready(h_rdy),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .out_valid(h_ovld), .out_ready(out_ready),
        .out_sum(h_osum), .out_mismatch(h_omis), .err_sticky(h_err), .samp_cnt(h_samp),
        .mism_cnt(h_mism), .state(h_state));

    function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        return s[8:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [8:0] s);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sum   = s;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sum = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_cmp++; if (d_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", d_rdy); end
        n_cmp++; if (d_ovld !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", d_ovld); end
        n_cmp++; if (d_osum !== 9'h000 || d_omis !== 1'b0) begin n_fail++; $display("FAIL reset_out_data got %h/%b exp 000/0", d_osum, d_omis); end
        n_cmp++; if (d_err !== 1'b0 || d_samp !== 16'd0 || d_mism !== 16'd0) begin n_fail++; $display("FAIL reset_stats got %b/%0d/%0d exp 0/0/0", d_err, d_samp, d_mism); end
        n_cmp++; if (d_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b exp 00", d_state); end
    endtask

    task automatic test_basic();
        apply_reset();
        en = 1'b1; out_ready = 1'b1;
        tick();
        n_cmp++; if (d_state !== 2'b01) begin n_fail++; $display("FAIL basic_run got %b exp 01", d_state); end
        beat(8'h7F, 8'h01, 9'h080);
        @(negedge clk);
        n_cmp++; if (d_rdy !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %b exp 1", d_rdy); end
        tick();
        n_cmp++; if (d_ovld !== 1'b1 || d_osum !== 9'h080 || d_omis !== 1'b0) begin n_fail++; $display("FAIL basic_pos_ovf got v%b s%h m%b exp v1 s080 m0", d_ovld, d_osum, d_omis); end
        n_cmp++; if (d_samp !== 16'd1) begin n_fail++; $display("FAIL basic_samp1 got %0d exp 1", d_samp); end
        beat(8'h80, 8'h80, 9'h100);
        tick();
        n_cmp++; if (d_osum !== 9'h100 || d_omis !== 1'b0 || d_err !== 1'b0) begin n_fail++; $display("FAIL basic_neg_min got s%h m%b e%b exp s100 m0 e0", d_osum, d_omis, d_err); end
        beat(8'h80, 8'h80, 9'h000);
        tick();
        n_cmp++; if (d_omis !== 1'b1 || d_mism !== 16'd1 || d_err !== 1'b1) begin n_fail++; $display("FAIL basic_mismatch got m%b c%0d e%b exp m1 c1 e1", d_omis, d_mism, d_err); end
        n_cmp++; if (d_samp !== 16'd3) begin n_fail++; $display("FAIL basic_samp3 got %0d exp 3", d_samp); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (d_ovld !== 1'b0 || d_err !== 1'b1) begin n_fail++; $display("FAIL basic_drain got v%b e%b exp v0 e1", d_ovld, d_err); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        en = 1'b1; out_ready = 1'b0;
        tick();
        beat(8'h02, 8'h03, 9'h005);
        tick();
        n_cmp++; if (d_ovld !== 1'b1 || d_osum !== 9'h005) begin n_fail++; $display("FAIL bp_first got v%b s%h exp v1 s005", d_ovld, d_osum); end
        beat(8'h01, 8'h01, 9'h002);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (d_rdy !== 1'b0 || d_osum !== 9'h005) begin n_fail++; $display("FAIL bp_hold got r%b s%h exp r0 s005", d_rdy, d_osum); end
            tick();
        end
        n_cmp++; if (d_samp !== 16'd1) begin n_fail++; $display("FAIL bp_samp_frozen got %0d exp 1", d_samp); end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (d_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", d_rdy); end
        tick();
        n_cmp++; if (d_ovld !== 1'b1 || d_osum !== 9'h002 || d_samp !== 16'd2) begin n_fail++; $display("FAIL bp_replace got v%b s%h c%0d exp v1 s002 c2", d_ovld, d_osum, d_samp); end
        beat(8'h03, 8'h04, 9'h007);
        tick();
        n_cmp++; if (d_ovld !== 1'b1 || d_osum !== 9'h007 || d_samp !== 16'd3) begin n_fail++; $display("FAIL bp_no_bubble got v%b s%h c%0d exp v1 s007 c3", d_ovld, d_osum, d_samp); end
        beat(8'h01, 8'h01, 9'h003);
        clr = 1'b1;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        n_cmp++; if (d_ovld !== 1'b1 || d_osum !== 9'h003 || d_omis !== 1'b1) begin n_fail++; $display("FAIL clr_forward got v%b s%h m%b exp v1 s003 m1", d_ovld, d_osum, d_omis); end
        n_cmp++; if (d_samp !== 16'd0 || d_mism !== 16'd0 || d_err !== 1'b0) begin n_fail++; $display("FAIL clr_stats got %0d/%0d/%b exp 0/0/0", d_samp, d_mism, d_err); end
        n_cmp++; if (d_state !== 2'b01) begin n_fail++; $display("FAIL clr_state got %b exp 01", d_state); end
    endtask

    task automatic test_saturate();
        apply_reset();
        en = 1'b1; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            beat(8'(i), 8'h10, ref_sum(8'(i), 8'h10) ^ 9'h001);
            tick();
        end
        n_cmp++; if (s_samp !== 2'd3 || s_mism !== 2'd3 || s_err !== 1'b1) begin n_fail++; $display("FAIL sat_counts got %0d/%0d/%b exp 3/3/1", s_samp, s_mism, s_err); end
        beat(8'hF0, 8'h05, 9'h1F5);
        clr = 1'b1;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        n_cmp++; if (s_samp !== 2'd0 || s_mism !== 2'd0 || s_err !== 1'b0) begin n_fail++; $display("FAIL sat_clr got %0d/%0d/%b exp 0/0/0", s_samp, s_mism, s_err); end
        n_cmp++; if (s_ovld !== 1'b1 || s_osum !== 9'h1F5 || s_omis !== 1'b0) begin n_fail++; $display("FAIL sat_clr_forward got v%b s%h m%b exp v1 s1F5 m0", s_ovld, s_osum, s_omis); end
    endtask

    task automatic test_halt();
        apply_reset();
        en = 1'b1; out_ready = 1'b1;
        tick();
        beat(8'h10, 8'h20, 9'h031);
        tick();
        n_cmp++; if (h_state !== 2'b10) begin n_fail++; $display("FAIL halt_enter got %b exp 10", h_state); end
        n_cmp++; if (h_samp !== 16'd1 || h_mism !== 16'd1 || h_err !== 1'b1) begin n_fail++; $display("FAIL halt_counted got %0d/%0d/%b exp 1/1/1", h_samp, h_mism, h_err); end
        n_cmp++; if (h_ovld !== 1'b1 || h_omis !== 1'b1 || h_osum !== 9'h031) begin n_fail++; $display("FAIL halt_forward got v%b m%b s%h exp v1 m1 s031", h_ovld, h_omis, h_osum); end
        beat(8'h01, 8'h02, 9'h003);
        @(negedge clk);
        n_cmp++; if (h_rdy !== 1'b0) begin n_fail++; $display("FAIL halt_ready got %b exp 0", h_rdy); end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (h_samp !== 16'd1 || h_ovld !== 1'b0 || h_state !== 2'b10) begin n_fail++; $display("FAIL halt_frozen got c%0d v%b st%b exp c1 v0 st10", h_samp, h_ovld, h_state); end
        in_valid = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++; if (h_state !== 2'b00 || h_samp !== 16'd0 || h_mism !== 16'd0 || h_err !== 1'b0) begin n_fail++; $display("FAIL halt_clr got st%b %0d/%0d/%b exp st00 0/0/0", h_state, h_samp, h_mism, h_err); end
        tick();
        n_cmp++; if (h_state !== 2'b01) begin n_fail++; $display("FAIL halt_rerun got %b exp 01", h_state); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        en = 1'b1; out_ready = 1'b0;
        tick();
        beat(8'h05, 8'h05, 9'h00A);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (d_ovld !== 1'b1) begin n_fail++; $display("FAIL areset_pre got %b exp 1", d_ovld); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (d_ovld !== 1'b0 || d_samp !== 16'd0 || d_state !== 2'b00 || d_rdy !== 1'b0) begin n_fail++; $display("FAIL areset_now got v%b c%0d st%b r%b exp v0 c0 st00 r0", d_ovld, d_samp, d_state, d_rdy); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        bit         m_run, m_pv, m_pm, m_err, acc, mis;
        logic [8:0] m_ps;
        int         m_samp, m_mism, s_samp_m, s_mism_m;
        apply_reset();
        m_run = 0; m_pv = 0; m_pm = 0; m_ps = '0; m_err = 0;
        m_samp = 0; m_mism = 0; s_samp_m = 0; s_mism_m = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            en        = ($urandom_range(0, 9) != 0);
            clr       = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_sum    = ref_sum(in_a, in_b);
            if ($urandom_range(0, 3) == 0) in_sum = in_sum ^ 9'($urandom_range(1, 511));
            @(negedge clk);
            n_cmp++; if (d_rdy !== (m_run && (!m_pv || out_ready))) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, d_rdy, m_run && (!m_pv || out_ready)); end
            n_cmp++; if (d_ovld !== m_pv || (m_pv && (d_osum !== m_ps || d_omis !== m_pm))) begin n_fail++; $display("FAIL rnd_out cyc %0d got v%b s%h m%b exp v%b s%h m%b", cyc, d_ovld, d_osum, d_omis, m_pv, m_ps, m_pm); end
            n_cmp++; if (d_samp !== 16'(m_samp) || d_mism !== 16'(m_mism) || d_err !== m_err) begin n_fail++; $display("FAIL rnd_stats cyc %0d got %0d/%0d/%b exp %0d/%0d/%b", cyc, d_samp, d_mism, d_err, m_samp, m_mism, m_err); end
            n_cmp++; if (s_samp !== 2'(s_samp_m) || s_mism !== 2'(s_mism_m)) begin n_fail++; $display("FAIL rnd_sat cyc %0d got %0d/%0d exp %0d/%0d", cyc, s_samp, s_mism, s_samp_m, s_mism_m); end
            n_cmp++; if (d_state !== {1'b0, m_run}) begin n_fail++; $display("FAIL rnd_state cyc %0d got %b exp %b", cyc, d_state, {1'b0, m_run}); end
            acc = in_valid && m_run && (!m_pv || out_ready);
            mis = (in_sum != ref_sum(in_a, in_b));
            if (acc) begin m_pv = 1; m_ps = in_sum; m_pm = mis; end
            else if (out_ready) m_pv = 0;
            if (clr) begin
                m_samp = 0; m_mism = 0; m_err = 0; s_samp_m = 0; s_mism_m = 0;
            end else if (acc) begin
                if (m_samp < 65535) m_samp++;
                if (s_samp_m < 3) s_samp_m++;
                if (mis) begin
                    m_err = 1;
                    if (m_mism < 65535) m_mism++;
                    if (s_mism_m < 3) s_mism_m++;
                end
            end
            m_run = en;
            tick();
        end
        in_valid = 1'b0; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_saturate();
        test_halt();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
